apb_controller: RTL and testbench
=================================

// Module: apb_controller
// PURPOSE
//  AHB-slave to APB-master stage of the AHB-to-APB bridge.
//  Accepts AHB-Lite transfers, decodes the target APB slave, and runs the APB SETUP/ENABLE sequence.
//  Stalls the AHB master with Hreadyout while the APB access is in progress.
//  Sits between the AHB master bus and the APB slave pins (Pselx/Penable/Pwrite/Paddr/Pwdata/Prdata).
// PARAMETERS
//  NSEL       4             number of APB slaves (width of Pselx)
//  BASE_ADDR  32'h8000_0000 start of the APB address window
//  SLOT_LOG2  10            log2 bytes per slave slot (1 KB per slave)
// PORTS
//  clock      in   1    single clock; all logic on posedge
//  Hreset     in   1    reset, asynchronous, active-high
//  Hreadyin   in   1    AHB bus ready (previous data phase done)
//  Htrans     in   2    AHB transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
//  Hwrite     in   1    AHB direction, 1=write
//  Haddr      in   32   AHB address (address phase)
//  Hwdata     in   32   AHB write data (data phase)
//  Prdata     in   32   APB read data from the selected slave
//  Hreadyout  out  1    slave ready to the AHB master
//  Hrdata     out  32   AHB read data
//  Hresp      out  2    AHB response; tied to OKAY (2'b00)
//  Pselx      out  NSEL one-hot APB slave select
//  Penable    out  1    APB enable strobe
//  Pwrite     out  1    APB direction
//  Paddr      out  32   APB address
//  Pwdata     out  32   APB write data
// BEHAVIOUR
//  - hit = Haddr in [BASE_ADDR, BASE_ADDR + NSEL<<SLOT_LOG2).
//  - valid = Hreadyin & Htrans[1] & hit. BUSY, IDLE and out-of-range transfers are ignored (OKAY, no APB access).
//  - Slave index = (Haddr-BASE_ADDR)>>SLOT_LOG2. The decoded one-hot select is captured with the address.
//  - FSM states: IDLE, WWAIT, READ, WRITE, RENABLE, WENABLE.
//  - Accept states are IDLE, RENABLE and WENABLE. In these states:
//      valid&Hwrite  -> WWAIT (latch Haddr, select, Pwrite=1)
//      valid&!Hwrite -> READ (latch Haddr, select, Pwrite=0)
//      else          -> IDLE
//  - WWAIT -> WRITE. Hwdata is latched into Pwdata at the end of WWAIT.
//  - WRITE -> WENABLE; READ -> RENABLE; unconditional, no APB wait states.
//  - Moore outputs, registered:
//      Hreadyout = 1 in IDLE/RENABLE/WENABLE, 0 in WWAIT/READ/WRITE.
//      Pselx = latched select in READ/WRITE/RENABLE/WENABLE, 0 otherwise.
//      Penable = 1 only in RENABLE/WENABLE.
//  - Paddr/Pwrite/Pwdata hold their last value after a transfer; only Pselx and Penable drop.
//  - Hrdata = Prdata (combinational) in RENABLE, 32'h0 otherwise.
//  - Latency from address-phase cycle T:
//      read:  SETUP at T+1, ENABLE at T+2 (Hrdata valid, Hreadyout=1)
//      write: WWAIT at T+1, SETUP at T+2, ENABLE at T+3
//  - Back-to-back transfers: an address phase sampled in RENABLE/WENABLE starts its sequence next cycle, with no IDLE gap.
//  - Hreset (asynchronous, any state, including mid-transfer):
//      state=IDLE, Hreadyout=1, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0.
//      Any partial APB access is abandoned and not replayed.
//  - Penable never rises without Pselx set in the preceding cycle; Pselx is always one-hot or zero.
// TESTING
//  1. Single write: Haddr=0x8000_0404, Hwdata=0xDEADBEEF.
//     -> SETUP: Pselx=0010, Pwrite=1, Paddr=0x8000_0404, Pwdata=0xDEADBEEF.
//     -> ENABLE next cycle; Hreadyout low for exactly 2 cycles.
//  2. Single read: Haddr=0x8000_0C00, Prdata=0x1234_5678.
//     -> Pselx=1000; Penable=1 at T+2; Hrdata=0x1234_5678 with Hreadyout=1 at T+2.
//  3. Write then read on consecutive accept slots.
//     -> READ SETUP in the cycle after WENABLE, no IDLE; Pwrite flips 1->0.
//  4. Rejected transfers: Haddr=0x8000_1000, or Htrans=BUSY, or Hreadyin=0.
//     -> FSM stays IDLE, Pselx=0, Hreadyout=1, Hresp=00.
//  5. Slot boundaries:
//     -> 0x8000_03FC gives Pselx=0001; 0x8000_0400 gives 0010; 0x8000_0FFC gives 1000.
//  6. Hreset asserted during WRITE.
//     -> Pselx=0, Penable=0, Hreadyout=1 immediately.
//     -> After release, a new read to 0x8000_0000 completes normally.

Source files
------------

// File: rtl/apb_controller.sv
// apb_controller: AHB-Lite slave to APB master stage, decodes the slave slot and runs SETUP/ENABLE.
module apb_controller #(
  parameter int          NSEL      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          SLOT_LOG2 = 10
) (
  input  logic            clock,
  input  logic            Hreset,
  input  logic            Hreadyin,
  input  logic [1:0]      Htrans,
  input  logic            Hwrite,
  input  logic [31:0]     Haddr,
  input  logic [31:0]     Hwdata,
  input  logic [31:0]     Prdata,
  output logic            Hreadyout,
  output logic [31:0]     Hrdata,
  output logic [1:0]      Hresp,
  output logic [NSEL-1:0] Pselx,
  output logic            Penable,
  output logic            Pwrite,
  output logic [31:0]     Paddr,
  output logic [31:0]     Pwdata
);
  typedef enum logic [2:0] {IDLE, WWAIT, READ, WRITE, RENABLE, WENABLE} state_t;
  localparam logic [31:0] WIN = 32'(NSEL) << SLOT_LOG2;
  state_t state, next;
  logic [31:0] off, idx;
  logic [NSEL-1:0] dec, sel;
  logic hit, valid, accept;
  assign off = Haddr - BASE_ADDR;
  assign hit = Haddr >= BASE_ADDR && off < WIN;
  assign idx = off >> SLOT_LOG2;
  assign valid = Hreadyin && (Htrans == 2'b10 || Htrans == 2'b11) && hit;
  assign accept = state == IDLE || state == RENABLE || state == WENABLE;
  assign Hresp = 2'b00;
  always_comb begin
    dec = '0;
    for (int i = 0; i < NSEL; i++) dec[i] = hit && idx == 32'(i);
  end
  always_ff @(posedge clock or posedge Hreset)
    if (Hreset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = accept ? (valid ? (Hwrite ? WWAIT : READ) : IDLE) :
           state == WWAIT ? WRITE :
           state == WRITE ? WENABLE : RENABLE;
  end
  always_comb begin
    Hreadyout = accept;
    Penable = state == RENABLE || state == WENABLE;
    Pselx = (state != IDLE && state != WWAIT) ? sel : '0;
    Hrdata = state == RENABLE ? Prdata : 32'h0;
  end
  // Address-side fields are captured with the address phase; write data one cycle later.
  always_ff @(posedge clock or posedge Hreset)
    if (Hreset) begin
      Paddr <= '0;
      Pwrite <= 1'b0;
      Pwdata <= '0;
      sel <= '0;
    end else begin
      if (accept && valid) begin
        Paddr <= Haddr;
        Pwrite <= Hwrite;
        sel <= dec;
      end
      if (state == WWAIT) Pwdata <= Hwdata;
    end
endmodule

// File: tb/tb_apb_controller.sv
// tb_apb_controller: table vectors, hand sequences and random traffic against a latency-based model.
module tb_apb_controller;
  logic clock = 1'b0, Hreset, Hreadyin, Hwrite, Hreadyout, Penable, Pwrite;
  logic [1:0] Htrans, Hresp;
  logic [31:0] Haddr, Hwdata, Prdata, Hrdata, Paddr, Pwdata;
  logic [3:0] Pselx;
  int n_chk = 0, n_pass = 0;
  always #5 clock = ~clock;
  apb_controller dut (
    .clock(clock), .Hreset(Hreset), .Hreadyin(Hreadyin), .Htrans(Htrans), .Hwrite(Hwrite),
    .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata), .Hreadyout(Hreadyout), .Hrdata(Hrdata),
    .Hresp(Hresp), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata)
  );
  // Model: a transfer accepted in cycle T occupies cycles T+1.. T+2 (read) or T+3 (write).
  bit m_act, m_w, m_pw;
  int m_t = 0, m_acc = 0;
  logic [31:0] m_addr, m_wdata;
  logic [3:0] m_sel;
  function automatic bit in_window(logic [31:0] a);
    return a >= 32'h8000_0000 && a < 32'h8000_1000;
  endfunction
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, a, e, $time);
  endtask
  task automatic model_reset();
    m_act = 0; m_pw = 0; m_addr = 0; m_wdata = 0; m_sel = 0;
  endtask
  task automatic model_edge();
    int ph = m_t - m_acc;
    bit free = !m_act || (m_w ? ph == 3 : ph == 2);
    if (m_act && m_w && ph == 1) m_wdata = Hwdata;
    if (free) begin
      if (Hreadyin && Htrans[1] && in_window(Haddr)) begin
        m_act = 1; m_w = Hwrite; m_pw = Hwrite; m_acc = m_t; m_addr = Haddr;
        m_sel = 4'b0001 << ((Haddr - 32'h8000_0000) / 1024);
      end else m_act = 0;
    end
    m_t++;
  endtask
  task automatic model_check();
    int ph = m_t - m_acc;
    bit en = m_act && (m_w ? ph == 3 : ph == 2);
    chk("Hreadyout", 32'(Hreadyout), 32'(!m_act || en));
    chk("Pselx", 32'(Pselx), (m_act && !(m_w && ph == 1)) ? 32'(m_sel) : 32'h0);
    chk("Penable", 32'(Penable), 32'(en));
    chk("Pwrite", 32'(Pwrite), 32'(m_pw));
    chk("Paddr", Paddr, m_addr);
    chk("Pwdata", Pwdata, m_wdata);
    chk("Hrdata", Hrdata, (en && !m_w) ? Prdata : 32'h0);
    chk("Hresp", 32'(Hresp), 32'h0);
  endtask
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    model_check();
  endtask
  task automatic drive(logic [1:0] tr, logic w, logic rdy, logic [31:0] a, logic [31:0] wd, logic [31:0] rd);
    Htrans = tr; Hwrite = w; Hreadyin = rdy; Haddr = a; Hwdata = wd; Prdata = rd;
  endtask
  typedef struct {
    logic [1:0] tr; logic w; logic rdy;
    logic [31:0] addr, wd, rd;
    logic [3:0] sel; logic [31:0] hr;
  } vec_t;
  vec_t v[10];
  initial begin
    logic [3:0] seen_sel;
    logic [31:0] seen_hr;
    int lows;
    v[0] = '{2'b10, 1'b1, 1'b1, 32'h8000_0404, 32'hDEAD_BEEF, 32'h0, 4'b0010, 32'h0};
    v[1] = '{2'b10, 1'b0, 1'b1, 32'h8000_0C00, 32'h0, 32'h1234_5678, 4'b1000, 32'h1234_5678};
    v[2] = '{2'b10, 1'b0, 1'b1, 32'h8000_1000, 32'h0, 32'h5A5A_5A5A, 4'b0000, 32'h0};
    v[3] = '{2'b01, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 32'h5A5A_5A5A, 4'b0000, 32'h0};
    v[4] = '{2'b10, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h5A5A_5A5A, 4'b0000, 32'h0};
    v[5] = '{2'b11, 1'b0, 1'b1, 32'h8000_03FC, 32'h0, 32'hAAAA_5555, 4'b0001, 32'hAAAA_5555};
    v[6] = '{2'b10, 1'b1, 1'b1, 32'h8000_0400, 32'h0BAD_F00D, 32'h0, 4'b0010, 32'h0};
    v[7] = '{2'b10, 1'b0, 1'b1, 32'h8000_0FFC, 32'h0, 32'h0F0F_0F0F, 4'b1000, 32'h0F0F_0F0F};
    v[8] = '{2'b00, 1'b1, 1'b1, 32'h8000_0800, 32'h1111_1111, 32'h0, 4'b0000, 32'h0};
    v[9] = '{2'b10, 1'b0, 1'b1, 32'h7FFF_FFFC, 32'h0, 32'h7777_7777, 4'b0000, 32'h0};
    Hreset = 1'b1;
    drive(2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    model_check();
    Hreset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(v[k].tr, v[k].w, v[k].rdy, v[k].addr, v[k].wd, v[k].rd);
      seen_sel = 0; seen_hr = 0; lows = 0;
      for (int c = 0; c < 4; c++) begin
        step();
        Htrans = 2'b00;
        seen_sel |= Pselx;
        if (Penable) seen_hr = Hrdata;
        if (!Hreadyout) lows++;
      end
      chk($sformatf("vec%0d sel", k), 32'(seen_sel), 32'(v[k].sel));
      chk($sformatf("vec%0d hrdata", k), seen_hr, v[k].hr);
      chk($sformatf("vec%0d stall", k), 32'(lows), v[k].sel == 0 ? 32'd0 : v[k].w ? 32'd2 : 32'd1);
      if (v[k].w && v[k].sel != 0) chk($sformatf("vec%0d pwdata", k), Pwdata, v[k].wd);
    end
    drive(2'b10, 1'b1, 1'b1, 32'h8000_0800, 32'h1111_2222, 32'h0);
    step();
    Htrans = 2'b00;
    step();
    step();
    chk("b2b wenable", {30'h0, Penable, Pwrite}, 32'h3);
    drive(2'b10, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 32'h0000_0055);
    step();
    Htrans = 2'b00;
    chk("b2b setup", {Pselx, Penable, Pwrite, Hreadyout}, {4'b0001, 3'b000});
    step();
    chk("b2b renable", {Penable, Hrdata}, {1'b1, 32'h0000_0055});
    drive(2'b10, 1'b1, 1'b1, 32'h8000_0404, 32'hCAFE_F00D, 32'h0);
    step();
    Htrans = 2'b00;
    step();
    chk("pre-reset sel", 32'(Pselx), 32'h2);
    #2 Hreset = 1'b1;
    #1;
    chk("reset async", {Pselx, Penable, Hreadyout, Pwrite}, {4'b0000, 1'b0, 1'b1, 1'b0});
    chk("reset paddr", Paddr, 32'h0);
    chk("reset pwdata", Pwdata, 32'h0);
    model_reset();
    @(negedge clock);
    Hreset = 1'b0;
    drive(2'b10, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 32'h0000_0009);
    step();
    Htrans = 2'b00;
    step();
    chk("post-reset read", {Pselx, Penable, Hrdata}, {4'b0001, 1'b1, 32'h9});
    for (int c = 0; c < 400; c++) begin
      Htrans = 2'($urandom);
      Hwrite = 1'($urandom);
      Hreadyin = ($urandom % 8) != 0;
      Haddr = ($urandom % 6 == 0) ? $urandom : 32'h8000_0000 + (($urandom % 4096) & 32'hFFC);
      Hwdata = $urandom;
      Prdata = $urandom;
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
